// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// controller state encoding and requester identifiers.
package rf_write_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Round-robin successor of a requester id.
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational readies/grant from the priority
// pointer, pointer flips to the other requester after every grant.
module rr_arb2
  import rf_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_ready,
  output logic b_ready,
  output logic gnt_vld,
  output logic gnt_id
);

  logic ptr;
  logic gnt_a;
  logic gnt_b;

  // A ready may be offered without its own valid; only the contested case
  // consults the pointer, so at most one handshake completes per cycle.
  always_comb begin
    a_ready = en && (!b_valid || (ptr == REQ_A));
    b_ready = en && (!a_valid || (ptr == REQ_B));
    gnt_a   = a_valid && a_ready;
    gnt_b   = b_valid && b_ready;
    gnt_vld = gnt_a || gnt_b;
    gnt_id  = gnt_b ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_A;
    end else if (gnt_vld) begin
      ptr <= other_req(gnt_id);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port owner: optional zero sweep after reset, then
// round-robin sharing of the port between ALU (A) and load (B) writeback.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W           = DEF_DATA_W,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter bit CLEAR_ON_RESET   = 1'b1,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam state_t            RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  logic              vld_p0;
  logic              gnt_id_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              we_p0;

  logic              reg_write_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  // Writes to the hard-wired zero register complete the handshake but are
  // never presented to the register array.
  function automatic logic write_enable(input logic [ADDR_W-1:0] addr);
    return !(ZERO_REG_DISCARD && (addr == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_CLEAR) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == LAST_ADDR) begin
        state_nxt = ST_RUN;
      end
    end
  end

  assign init_busy = (state == ST_CLEAR);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_RUN),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_ready (a_ready),
    .b_ready (b_ready),
    .gnt_vld (vld_p0),
    .gnt_id  (gnt_id_p0)
  );

  // Stage p0: select the winning request.
  always_comb begin
    addr_p0 = (gnt_id_p0 == REQ_B) ? b_addr : a_addr;
    data_p0 = (gnt_id_p0 == REQ_B) ? b_data : a_data;
    we_p0   = write_enable(addr_p0);
  end

  // Stage p1: registered write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_p1 <= 1'b0;
      waddr_p1     <= '0;
      wdata_p1     <= '0;
    end else if (state == ST_CLEAR) begin
      reg_write_p1 <= 1'b1;
      waddr_p1     <= cnt;
      wdata_p1     <= '0;
    end else if (vld_p0) begin
      reg_write_p1 <= we_p0;
      waddr_p1     <= addr_p0;
      wdata_p1     <= data_p0;
    end else begin
      reg_write_p1 <= 1'b0;
    end
  end

  assign rf_reg_write = reg_write_p1;
  assign rf_waddr     = waddr_p1;
  assign rf_wdata     = wdata_p1;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scoreboard bench for rf_write_arbiter (clear sweep, arbitration,
// zero-register discard, mid-sweep reset, and no-clear configuration).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_reg_write;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_busy;

  logic        n_rst;
  logic        n_a_valid, n_b_valid;
  logic [4:0]  n_a_addr, n_b_addr;
  logic [31:0] n_a_data, n_b_data;
  logic        n_a_ready, n_b_ready;
  logic        n_rf_reg_write;
  logic [4:0]  n_rf_waddr;
  logic [31:0] n_rf_wdata;
  logic        n_init_busy;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_ptr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CLEAR_ON_RESET(1'b1), .ZERO_REG_DISCARD(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_reg_write(rf_reg_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_busy(init_busy)
  );

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CLEAR_ON_RESET(1'b0), .ZERO_REG_DISCARD(1'b1)) dut_nc (
    .clk(clk), .rst(n_rst),
    .a_valid(n_a_valid), .a_addr(n_a_addr), .a_data(n_a_data), .a_ready(n_a_ready),
    .b_valid(n_b_valid), .b_addr(n_b_addr), .b_data(n_b_data), .b_ready(n_b_ready),
    .rf_reg_write(n_rf_reg_write), .rf_waddr(n_rf_waddr), .rf_wdata(n_rf_wdata),
    .init_busy(n_init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at posedge+1 with valids low; checks all 32 sweep writes.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk({tag, "_we"}, 32'(rf_reg_write), 32'd1);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(i));
      chk({tag, "_wdata"}, rf_wdata, 32'd0);
      chk({tag, "_busy"}, 32'(init_busy), 32'(i != 31));
      if (i != 31) begin
        chk({tag, "_ardy"}, 32'(a_ready), 32'd0);
        chk({tag, "_brdy"}, 32'(b_ready), 32'd0);
      end
    end
  endtask

  // One RUN cycle: drive, check readies, push expected write, clock, pop and compare.
  task automatic run_cycle(input string tag,
                           input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                           output logic ga, output logic gb);
    logic ear, ebr;
    exp_t e, g;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    ear = !bv || (m_ptr == 1'b0);
    ebr = !av || (m_ptr == 1'b1);
    chk({tag, "_ardy"}, 32'(a_ready), 32'(ear));
    chk({tag, "_brdy"}, 32'(b_ready), 32'(ebr));
    ga = av && ear;
    gb = bv && ebr;
    if (ga) begin
      e.we = (aa != 5'd0); e.addr = aa; e.data = ad; m_ptr = 1'b1;
    end else if (gb) begin
      e.we = (ba != 5'd0); e.addr = ba; e.data = bd; m_ptr = 1'b0;
    end else begin
      e.we = 1'b0; e.addr = m_addr; e.data = m_data;
    end
    m_addr = e.addr;
    m_data = e.data;
    sbq.push_back(e);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    g = sbq.pop_front();
    chk({tag, "_we"}, 32'(rf_reg_write), 32'(g.we));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(g.addr));
    chk({tag, "_wdata"}, rf_wdata, g.data);
  endtask

  initial begin
    logic ga, gb;
    logic [4:0] a_idx;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    n_rst = 1'b1; n_a_valid = 1'b0; n_b_valid = 1'b0;
    n_a_addr = '0; n_b_addr = '0; n_a_data = '0; n_b_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(rf_reg_write), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_ardy", 32'(a_ready), 32'd0);
    chk("rst_brdy", 32'(b_ready), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    sweep_check("sweep1");
    m_ptr = 1'b0; m_addr = 5'd31; m_data = 32'd0;

    run_cycle("a_only", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ga, gb);
    chk("a_only_gnt", 32'(ga), 32'd1);
    run_cycle("b_only", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, ga, gb);
    chk("b_only_gnt", 32'(gb), 32'd1);

    a_idx = 5'd1;
    for (int k = 0; k < 4; k++) begin
      run_cycle("abab", 1'b1, a_idx, 32'hA000 + 32'(a_idx), 1'b1, 5'd9, 32'hB000 + 32'(k), ga, gb);
      chk("abab_gnt_a", 32'(ga), 32'((k % 2) == 0));
      chk("abab_gnt_b", 32'(gb), 32'((k % 2) == 1));
      if (ga) a_idx = a_idx + 5'd1;
    end

    run_cycle("idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gb);
    run_cycle("zero", 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, ga, gb);
    chk("zero_gnt", 32'(ga), 32'd1);
    run_cycle("after_zero", 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, ga, gb);
    chk("after_zero_gnt_b", 32'(gb), 32'd1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("mid_busy", 32'(init_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(rf_reg_write), 32'd0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    chk("mid_rst_busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    sweep_check("sweep2");
    m_ptr = 1'b0; m_addr = 5'd31; m_data = 32'd0;
    run_cycle("post_sweep2", 1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, ga, gb);
    chk("post_sweep2_gnt_a", 32'(ga), 32'd1);

    chk("nc_rst_busy", 32'(n_init_busy), 32'd0);
    chk("nc_rst_we", 32'(n_rf_reg_write), 32'd0);
    n_rst = 1'b0;
    n_a_valid = 1'b1; n_a_addr = 5'd3; n_a_data = 32'hCAFE;
    #1;
    chk("nc_ardy", 32'(n_a_ready), 32'd1);
    chk("nc_busy", 32'(n_init_busy), 32'd0);
    @(posedge clk); #1;
    n_a_valid = 1'b0;
    chk("nc_we", 32'(n_rf_reg_write), 32'd1);
    chk("nc_waddr", 32'(n_rf_waddr), 32'd3);
    chk("nc_wdata", n_rf_wdata, 32'hCAFE);
    @(posedge clk); #1;
    chk("nc_idle_we", 32'(n_rf_reg_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
